eager_fork: RTL and testbench



---
 rtl/eager_fork.sv | 85 ++++++++
 tb/tb_eager_fork.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/eager_fork.sv
// eager_fork: registered two-way eager fork for a valid/ready dataflow fabric.
// One accepted token is held in a single-entry register and offered to both
// branches. Each branch may take it in a different cycle. The token retires
// once both branches have taken it. Output valids come straight from state,
// so there is no combinational path from any ready to any output valid.
module eager_fork #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] io_din,
  input  logic                  io_din_v,
  output logic                  io_din_r,
  output logic [DATA_WIDTH-1:0] io_dout_1,
  output logic                  io_dout_1_v,
  input  logic                  io_dout_1_r,
  output logic [DATA_WIDTH-1:0] io_dout_2,
  output logic                  io_dout_2_v,
  input  logic                  io_dout_2_r
);

  logic                  full_reg, full_next;
  logic [DATA_WIDTH-1:0] data_reg, data_next;
  logic                  sent_1_reg, sent_1_next;
  logic                  sent_2_reg, sent_2_next;

  logic take_1, take_2;
  logic taken_1, taken_2;
  logic done;
  logic din_xfer;

  // Handshake decode and next-state selection (load beats retire beats
  // accumulate). Loading a new token also clears the sent flags, so a retire
  // and a load in the same cycle leave no bubble.
  always_comb begin
    io_dout_1   = data_reg;
    io_dout_2   = data_reg;
    io_dout_1_v = full_reg & ~sent_1_reg;
    io_dout_2_v = full_reg & ~sent_2_reg;

    take_1  = io_dout_1_v & io_dout_1_r;
    take_2  = io_dout_2_v & io_dout_2_r;
    taken_1 = sent_1_reg | take_1;
    taken_2 = sent_2_reg | take_2;
    done    = full_reg & taken_1 & taken_2;

    io_din_r = ~reset & (~full_reg | done);
    din_xfer = io_din_v & io_din_r;

    full_next   = full_reg;
    data_next   = data_reg;
    sent_1_next = sent_1_reg;
    sent_2_next = sent_2_reg;

    if (din_xfer) begin
      full_next   = 1'b1;
      data_next   = io_din;
      sent_1_next = 1'b0;
      sent_2_next = 1'b0;
    end else if (done) begin
      full_next   = 1'b0;
      sent_1_next = 1'b0;
      sent_2_next = 1'b0;
    end else begin
      sent_1_next = taken_1;
      sent_2_next = taken_2;
    end
  end

  // State register; reset discards any held or partially delivered token.
  always_ff @(posedge clock) begin
    if (reset) begin
      full_reg   <= 1'b0;
      data_reg   <= '0;
      sent_1_reg <= 1'b0;
      sent_2_reg <= 1'b0;
    end else begin
      full_reg   <= full_next;
      data_reg   <= data_next;
      sent_1_reg <= sent_1_next;
      sent_2_reg <= sent_2_next;
    end
  end

endmodule

// File: tb/tb_eager_fork.sv
// tb_eager_fork: directed and randomized checks of eager_fork against a
// token-counting reference model (tokens accepted / delivered per branch /
// retired), compared every cycle.
module tb_eager_fork;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] io_din = 8'h00;
  logic       io_din_v = 1'b0;
  logic       io_din_r;
  logic [7:0] io_dout_1;
  logic       io_dout_1_v;
  logic       io_dout_1_r = 1'b0;
  logic [7:0] io_dout_2;
  logic       io_dout_2_v;
  logic       io_dout_2_r = 1'b0;

  int checks = 0;
  int errors = 0;

  // Reference model: counts of tokens accepted, delivered to each branch and
  // retired, plus the value of the most recently loaded token.
  int         n_acc = 0;
  int         n_ret = 0;
  int         n_del1 = 0;
  int         n_del2 = 0;
  logic [7:0] last_tok = 8'h00;

  eager_fork #(.DATA_WIDTH(8)) dut (
    .clock       (clock),
    .reset       (reset),
    .io_din      (io_din),
    .io_din_v    (io_din_v),
    .io_din_r    (io_din_r),
    .io_dout_1   (io_dout_1),
    .io_dout_1_v (io_dout_1_v),
    .io_dout_1_r (io_dout_1_r),
    .io_dout_2   (io_dout_2),
    .io_dout_2_v (io_dout_2_v),
    .io_dout_2_r (io_dout_2_r)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, compare outputs
  // against the model, then advance the model at the rising edge.
  task automatic step(input logic [7:0] din, input logic v, input logic r1,
                      input logic r2, input logic rst, output logic accepted);
    logic m_full, m_v1, m_v2, m_t1, m_t2, m_ret, m_dinr;
    @(negedge clock);
    io_din = din; io_din_v = v; io_dout_1_r = r1; io_dout_2_r = r2; reset = rst;
    #1;
    m_full = (n_acc > n_ret);
    m_v1   = (n_del1 < n_acc);
    m_v2   = (n_del2 < n_acc);
    m_t1   = m_v1 & r1;
    m_t2   = m_v2 & r2;
    m_ret  = m_full && (n_del1 + int'(m_t1) == n_acc) && (n_del2 + int'(m_t2) == n_acc);
    m_dinr = !rst && (!m_full || m_ret);
    chk("dout_1_v", {7'd0, io_dout_1_v}, {7'd0, m_v1});
    chk("dout_2_v", {7'd0, io_dout_2_v}, {7'd0, m_v2});
    chk("dout_1",   io_dout_1, last_tok);
    chk("dout_2",   io_dout_2, last_tok);
    chk("din_r",    {7'd0, io_din_r}, {7'd0, m_dinr});
    accepted = v & m_dinr;
    @(posedge clock);
    if (rst) begin
      n_acc = 0; n_ret = 0; n_del1 = 0; n_del2 = 0; last_tok = 8'h00;
    end else begin
      if (m_t1) begin n_del1++; $display("branch1 took %02h", last_tok); end
      if (m_t2) begin n_del2++; $display("branch2 took %02h", last_tok); end
      if (m_ret) n_ret++;
      if (accepted) begin
        n_acc++;
        last_tok = din;
        $display("accept %02h", din);
      end
    end
  endtask

  initial begin
    logic       acc;
    logic [7:0] cur;
    logic       cur_v;

    // Two reset cycles before any comparison so the state is defined.
    repeat (2) @(posedge clock);
    step(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, acc);

    // Basic fork.
    step(8'h5A, 1'b1, 1'b1, 1'b1, 1'b0, acc);
    step(8'h00, 1'b0, 1'b1, 1'b1, 1'b0, acc);
    step(8'h00, 1'b0, 1'b1, 1'b1, 1'b0, acc);

    // Streaming 0x01..0x08 with both branches always ready.
    for (int i = 1; i <= 8; i++) step(8'(i), 1'b1, 1'b1, 1'b1, 1'b0, acc);
    step(8'h00, 1'b0, 1'b1, 1'b1, 1'b0, acc);
    step(8'h00, 1'b0, 1'b1, 1'b1, 1'b0, acc);

    // Skewed branch: branch 2 stalls three cycles.
    step(8'h33, 1'b1, 1'b1, 1'b0, 1'b0, acc);
    for (int i = 0; i < 3; i++) step(8'h00, 1'b0, 1'b1, 1'b0, 1'b0, acc);
    step(8'h00, 1'b0, 1'b1, 1'b1, 1'b0, acc);
    step(8'h00, 1'b0, 1'b1, 1'b1, 1'b0, acc);

    // Both stalled for five cycles.
    step(8'hC4, 1'b1, 1'b0, 1'b0, 1'b0, acc);
    for (int i = 0; i < 5; i++) step(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, acc);
    step(8'h00, 1'b0, 1'b1, 1'b1, 1'b0, acc);

    // Simultaneous retire and load.
    step(8'h10, 1'b1, 1'b0, 1'b0, 1'b0, acc);
    step(8'h00, 1'b0, 1'b1, 1'b0, 1'b0, acc);
    step(8'h11, 1'b1, 1'b1, 1'b1, 1'b0, acc);
    step(8'h00, 1'b0, 1'b1, 1'b1, 1'b0, acc);

    // Reset mid-token after branch 1 has taken it.
    step(8'h7E, 1'b1, 1'b0, 1'b0, 1'b0, acc);
    step(8'h00, 1'b0, 1'b1, 1'b0, 1'b0, acc);
    step(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, acc);
    step(8'h00, 1'b0, 1'b1, 1'b1, 1'b0, acc);
    step(8'h00, 1'b0, 1'b1, 1'b1, 1'b0, acc);

    // Randomized traffic; the producer holds data and valid until accepted.
    cur   = 8'($urandom);
    cur_v = 1'b0;
    for (int i = 0; i < 400; i++) begin
      logic rst;
      if (!cur_v) cur_v = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 59) == 0);
      step(cur, cur_v, 1'($urandom), 1'($urandom), rst, acc);
      if (acc || rst) begin
        cur   = 8'($urandom);
        cur_v = 1'b0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
